// File: rtl/regfile_mp.sv
// Multi-port architectural register file: ISSUE_WIDTH write lanes, 2*ISSUE_WIDTH
// registered read ports with same-cycle write bypass, and a post-reset clear sequencer.

module regfile_mp_rdport #(
    parameter int REGNAME_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ISSUE_WIDTH   = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_run,
    input  logic                                 i_rd_en,
    input  logic [REGNAME_WIDTH-1:0]             i_rd_addr,
    input  logic [DATA_WIDTH-1:0]                i_rf_val,
    input  logic [ISSUE_WIDTH-1:0]               i_wr_en,
    input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0] i_wr_addr,
    input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    i_wr_data,
    output logic [DATA_WIDTH-1:0]                o_rd_data,
    output logic                                 o_rd_valid
);
    logic [DATA_WIDTH-1:0] w_val;

    // Ascending lane scan: the highest-numbered matching writer supplies the bypass value.
    always_comb begin
        w_val = i_rf_val;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (i_wr_en[l] && i_rd_addr != '0 &&
                i_wr_addr[l*REGNAME_WIDTH +: REGNAME_WIDTH] == i_rd_addr)
                w_val = i_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else if (i_run && i_rd_en) begin
            o_rd_data  <= w_val;
            o_rd_valid <= 1'b1;
        end else begin
            o_rd_valid <= 1'b0;
        end
    end
endmodule

module regfile_mp #(
    parameter int REGNAME_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ISSUE_WIDTH   = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [ISSUE_WIDTH-1:0]                 i_wr_en,
    input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0]   i_wr_addr,
    input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]      i_wr_data,
    input  logic [2*ISSUE_WIDTH-1:0]               i_rd_en,
    input  logic [2*ISSUE_WIDTH*REGNAME_WIDTH-1:0] i_rd_addr,
    output logic [2*ISSUE_WIDTH*DATA_WIDTH-1:0]    o_rd_data,
    output logic [2*ISSUE_WIDTH-1:0]               o_rd_valid,
    output logic                                   o_ready,
    output logic                                   o_wr_conflict
);
    localparam int NUM_REGS  = 2**REGNAME_WIDTH;
    localparam int NUM_PORTS = 2*ISSUE_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                                 r_state;
    logic [REGNAME_WIDTH-1:0]               r_cnt;
    logic                                   r_ready;
    logic                                   r_wr_conflict;
    logic                                   w_conflict;
    logic                                   w_run;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    w_regs;

    assign w_run         = (r_state == ST_RUN);
    assign o_ready       = r_ready;
    assign o_wr_conflict = r_wr_conflict;

    always_comb begin
        w_conflict = 1'b0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            for (int m = l + 1; m < ISSUE_WIDTH; m++) begin
                if (i_wr_en[l] && i_wr_en[m] &&
                    i_wr_addr[l*REGNAME_WIDTH +: REGNAME_WIDTH] != '0 &&
                    i_wr_addr[l*REGNAME_WIDTH +: REGNAME_WIDTH] ==
                    i_wr_addr[m*REGNAME_WIDTH +: REGNAME_WIDTH])
                    w_conflict = 1'b1;
            end
        end
    end

    // Clear sequencer walks r1..r(NUM_REGS-1); r0 needs no storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_INIT;
            r_cnt         <= REGNAME_WIDTH'(1);
            r_ready       <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_wr_conflict <= 1'b0;
            r_cnt         <= r_cnt + REGNAME_WIDTH'(1);
            if (r_cnt == REGNAME_WIDTH'(NUM_REGS - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            r_wr_conflict <= w_conflict;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign w_regs[g] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] r_q;
            // Later lanes overwrite earlier ones in the same cycle, so the youngest write wins.
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    if (r_state == ST_INIT) begin
                        if (r_cnt == REGNAME_WIDTH'(g))
                            r_q <= '0;
                    end else begin
                        for (int l = 0; l < ISSUE_WIDTH; l++) begin
                            if (i_wr_en[l] &&
                                i_wr_addr[l*REGNAME_WIDTH +: REGNAME_WIDTH] == REGNAME_WIDTH'(g))
                                r_q <= i_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            assign w_regs[g] = r_q;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        regfile_mp_rdport #(
            .REGNAME_WIDTH (REGNAME_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .ISSUE_WIDTH   (ISSUE_WIDTH)
        ) u_rdport (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_run      (w_run),
            .i_rd_en    (i_rd_en[p]),
            .i_rd_addr  (i_rd_addr[p*REGNAME_WIDTH +: REGNAME_WIDTH]),
            .i_rf_val   (w_regs[i_rd_addr[p*REGNAME_WIDTH +: REGNAME_WIDTH]]),
            .i_wr_en    (i_wr_en),
            .i_wr_addr  (i_wr_addr),
            .i_wr_data  (i_wr_data),
            .o_rd_data  (o_rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .o_rd_valid (o_rd_valid[p])
        );
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port architectural register file: the successor to the fixed dual-issue (2-write / 4-read) decoder↔register-file interface. It serves ISSUE_WIDTH decode lanes, each with two source-read ports and one destination-write port. Reads are registered and include same-cycle write bypass. After reset, a built-in init sequencer clears the storage. The block sits between decode/rename and the issue/execute stage.

## Interface
- REGNAME_WIDTH, 5, register-name width; NUM_REGS = 2**REGNAME_WIDTH
- DATA_WIDTH, 32, register data width
- ISSUE_WIDTH, 2, number of lanes; read ports = 2*ISSUE_WIDTH, write ports = ISSUE_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  ISSUE_WIDTH  per-lane write enable; bit l = lane l
- wr_addr  in  ISSUE_WIDTH*REGNAME_WIDTH  lane l at [l*REGNAME_WIDTH +: REGNAME_WIDTH]
- wr_data  in  ISSUE_WIDTH*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH]
- rd_en  in  2*ISSUE_WIDTH  read port p = 2*l+s (lane l, source s∈{0,1})
- rd_addr  in  2*ISSUE_WIDTH*REGNAME_WIDTH  port p at [p*REGNAME_WIDTH +: REGNAME_WIDTH]
- rd_data  out  2*ISSUE_WIDTH*DATA_WIDTH  registered read result, port p at [p*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  2*ISSUE_WIDTH  1-cycle pulse: rd_data[p] was updated on this edge
- ready  out  1  storage initialised; accesses accepted
- wr_conflict  out  1  registered pulse: two or more lanes wrote the same nonzero address

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops. Register 0 is hardwired to zero; writes to it are discarded and reads of it return 0.
- State machine with states INIT and RUN.
  - rst=1 → INIT at the next edge; clear counter cnt=1.
  - Every INIT cycle with rst=0: reg[cnt]←0, then cnt++. When reg[NUM_REGS-1] has been written: → RUN, ready←1.
  - RUN holds until rst.
- In INIT:
  - wr_en and rd_en are ignored.
  - rd_valid=0.
  - rd_data holds its value.
- Write (RUN): for each lane with wr_en=1 and wr_addr≠0, reg[addr]←data at the edge.
  - Same-address collision: the highest-numbered lane wins (younger in program order).
  - wr_conflict←1 for one cycle when any two enabled lanes share a nonzero address; otherwise 0.
- Read (RUN): for each port with rd_en=1:
  - rd_data[p]←value at the edge, and rd_valid[p]←1.
  - Value precedence: 0 if addr=0; else the highest-numbered lane with wr_en=1 and wr_addr=addr in the same cycle (bypass, write-before-read); else reg[addr].
- Read port with rd_en=0: rd_valid[p]←0 and rd_data[p] holds.
- rst mid-operation, on that edge:
  - ready←0, rd_valid←0, wr_conflict←0.
  - Any concurrent writes are dropped.
  - Register contents are re-cleared by the init sequence.

## Timing
- Reset values (the edge where rst=1): ready=0, rd_valid=0, wr_conflict=0, rd_data=0, state=INIT, cnt=1.
- Init length: NUM_REGS-1 cycles with rst=0. ready rises on the (NUM_REGS-1)th edge after rst deasserts (31 edges at default). Accesses are accepted from the cycle ready is seen high.
- Read latency: 1 cycle. The address is presented in cycle N; rd_data/rd_valid are valid in cycle N+1.
- Write latency: a write in cycle N is visible to reads issued in cycle N (bypass) and later.
- No backpressure. All ports are accepted every RUN cycle.
- The bypass path is combinational from wr_* to the rd_data flops. No combinational path from any input to any output.

## Test plan
- **Reset/init:** assert rst 3 cycles, release.
  - ready=0 for the first 30 edges and =1 at edge 31.
  - rd_valid stays 0 throughout, even with rd_en=all-ones.
  - After ready, all 32 registers read 0.
- **Basic write/read:** lane0 writes r5=0xDEADBEEF in cycle N; port 2 reads r5 in cycle N+1 → rd_data[2]=0xDEADBEEF, rd_valid=4'b0100 in cycle N+2.
- **Bypass + collision:** in one cycle, lane0 writes r7=0x11, lane1 writes r7=0x22, and port 0 reads r7.
  - Next cycle: rd_data[0]=0x22 and wr_conflict=1.
  - A later read of r7 returns 0x22.
- **Zero register:** lane1 writes r0=0xFFFFFFFF and ports 0–3 read r0 in the same cycle → all return 0, wr_conflict=0, and later reads of r0 return 0.
- **Hold on disable:** read r3=0x55 on port 1, then deassert rd_en[1] for 4 cycles while writing r3=0x66 → rd_data[1] stays 0x55 and rd_valid[1]=0.
- **Reset mid-operation:** after writing r9=0xA5, pulse rst for 1 cycle concurrent with lane0 writing r9=0x5A.
  - ready drops next edge and re-asserts 31 edges after rst falls.
  - r9 then reads 0.
